// File: rtl/coin_change_unit.sv
// ----------------------------------------------------------------------------
// coin_change_unit
//
// Cash front end of the vending controller. Coin and bill pulses add into a
// cents balance. The vending FSM can deduct a price or cancel. A cancel
// returns the whole balance as a greedy quarter/dime/nickel/penny breakdown.
//
// Ports
//   clk           rising-edge system clock
//   rst           asynchronous, active-low reset
//   nickel        1-cycle pulse: +5 cents
//   dime          1-cycle pulse: +10 cents
//   quarter       1-cycle pulse: +25 cents
//   dollar        1-cycle pulse: +100 cents
//   deduct        1-cycle purchase request
//   deduct_amt    price in cents, sampled with deduct
//   cancel        1-cycle request to return the whole balance
//   balance       registered balance in cents
//   deduct_ok     pulse: deduction performed
//   deduct_fail   pulse: insufficient funds, nothing deducted
//   coin_reject   pulse: this cycle's coins refused (would exceed BAL_MAX)
//   change_valid  pulse: a new breakdown is on the coin outputs
//   quarter_o     quarters to return (0..20)
//   dime_o        dimes to return (0..2)
//   nickel_o      nickels to return (0..1)
//   penny_o       pennies to return (0..4)
//
// There is no valid/ready handshake. Every input is a one-cycle request, and
// every response is a registered one-cycle pulse on the following cycle.
// BAL_MAX must be <= 511 so that it fits the 9-bit balance.
// ----------------------------------------------------------------------------
module coin_change_unit #(
    parameter int BAL_MAX = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       dollar,
    input  logic       deduct,
    input  logic [8:0] deduct_amt,
    input  logic       cancel,
    output logic [8:0] balance,
    output logic       deduct_ok,
    output logic       deduct_fail,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [4:0] quarter_o,
    output logic [2:0] dime_o,
    output logic [2:0] nickel_o,
    output logic [2:0] penny_o
);

    // 11-bit working width: balance (<=511) plus ins (<=140) cannot wrap.
    localparam logic [10:0] BAL_MAX_W = 11'(BAL_MAX);

    logic [10:0] ins;
    logic [10:0] bal_ext;
    logic [10:0] amt_ext;
    logic [10:0] bal_eff;
    logic [10:0] sum_raw;
    logic [8:0]  bal_next;
    logic        do_deduct;
    logic        can_pay;
    logic        accept;
    logic [4:0]  rem25;
    logic [4:0]  q_n;
    logic [2:0]  d_n;
    logic [2:0]  n_n;
    logic [2:0]  p_n;

    always_comb begin
        ins = (nickel  ? 11'd5   : 11'd0)
            + (dime    ? 11'd10  : 11'd0)
            + (quarter ? 11'd25  : 11'd0)
            + (dollar  ? 11'd100 : 11'd0);

        bal_ext = {2'b00, balance};
        amt_ext = {2'b00, deduct_amt};

        // Cancel wins over deduct. A deduct that coincides with a cancel is dropped.
        do_deduct = deduct & ~cancel;

        // Affordability is judged against the registered balance only. Coins
        // arriving in the same cycle cannot fund the purchase.
        can_pay = (amt_ext <= bal_ext);
        bal_eff = (do_deduct && can_pay) ? (bal_ext - amt_ext) : bal_ext;

        // The overflow check uses the post-deduction balance. This lets a
        // purchase make room for coins inserted in the same cycle. Coins are
        // accepted whole or not at all.
        sum_raw  = bal_eff + ins;
        accept   = (sum_raw <= BAL_MAX_W);
        bal_next = accept ? 9'(sum_raw) : 9'(bal_eff);

        // Greedy breakdown of the amount that a cancel would return.
        rem25 = 5'(bal_next % 9'd25);
        q_n   = 5'(bal_next / 9'd25);
        d_n   = 3'(rem25 / 5'd10);
        n_n   = 3'((rem25 % 5'd10) / 5'd5);
        p_n   = 3'(rem25 % 5'd5);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            balance      <= 9'd0;
            deduct_ok    <= 1'b0;
            deduct_fail  <= 1'b0;
            coin_reject  <= 1'b0;
            change_valid <= 1'b0;
            quarter_o    <= 5'd0;
            dime_o       <= 3'd0;
            nickel_o     <= 3'd0;
            penny_o      <= 3'd0;
        end else begin
            deduct_ok    <= do_deduct & can_pay;
            deduct_fail  <= do_deduct & ~can_pay;
            coin_reject  <= ~accept;
            change_valid <= cancel;
            if (cancel) begin
                balance   <= 9'd0;
                quarter_o <= q_n;
                dime_o    <= d_n;
                nickel_o  <= n_n;
                penny_o   <= p_n;
            end else begin
                // The coin outputs keep their last breakdown until the next cancel.
                balance <= bal_next;
            end
        end
    end

endmodule

// File: tb/tb_coin_change_unit.sv
// ----------------------------------------------------------------------------
// tb_coin_change_unit
//
// Directed plus short random stimulus for coin_change_unit. Each step drives
// one cycle of inputs and pushes the reference model's expected output word
// onto exp_q. After the next rising edge, the word is popped and compared
// with the DUT. Named spot checks pin the headline values independently of
// the model.
// ----------------------------------------------------------------------------
module tb_coin_change_unit;

    localparam int BAL_MAX = 500;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       nickel, dime, quarter, dollar, deduct, cancel;
    logic [8:0] deduct_amt;
    logic [8:0] balance;
    logic       deduct_ok, deduct_fail, coin_reject, change_valid;
    logic [4:0] quarter_o;
    logic [2:0] dime_o, nickel_o, penny_o;

    always #5 clk = ~clk;

    coin_change_unit #(.BAL_MAX(BAL_MAX)) dut (
        .clk(clk), .rst(rst),
        .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar),
        .deduct(deduct), .deduct_amt(deduct_amt), .cancel(cancel),
        .balance(balance), .deduct_ok(deduct_ok), .deduct_fail(deduct_fail),
        .coin_reject(coin_reject), .change_valid(change_valid),
        .quarter_o(quarter_o), .dime_o(dime_o), .nickel_o(nickel_o),
        .penny_o(penny_o)
    );

    // ---------------- scoreboard state ----------------
    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [26:0] exp_q[$];

    // Reference model state
    int          m_bal = 0;
    logic [4:0]  m_q = 5'd0;
    logic [2:0]  m_d = 3'd0, m_n = 3'd0, m_p = 3'd0;

    function automatic logic [26:0] pack(input logic [8:0] bal, input logic ok,
                                         input logic fl, input logic rj,
                                         input logic cv, input logic [4:0] q,
                                         input logic [2:0] d, input logic [2:0] n,
                                         input logic [2:0] p);
        return {bal, ok, fl, rj, cv, q, d, n, p};
    endfunction

    function automatic logic [26:0] dut_word();
        return pack(balance, deduct_ok, deduct_fail, coin_reject, change_valid,
                    quarter_o, dime_o, nickel_o, penny_o);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver task ----------------
    task automatic step(input int nk, input int dm, input int qt, input int dl,
                        input int ded, input int amt, input int can, input string tag);
        int ins, eff, chg;
        logic ok, fl, rj;
        logic [26:0] exp_w;
        logic [26:0] obs_w;
        ok = 1'b0; fl = 1'b0; rj = 1'b0;
        ins = 5 * nk + 10 * dm + 25 * qt + 100 * dl;
        eff = m_bal;
        if (can == 0 && ded != 0) begin
            if (amt <= m_bal) begin
                ok  = 1'b1;
                eff = m_bal - amt;
            end else begin
                fl = 1'b1;
            end
        end
        if (eff + ins > BAL_MAX) begin
            rj  = 1'b1;
            ins = 0;
        end
        if (can != 0) begin
            chg = eff + ins;
            m_q = 5'd0; m_d = 3'd0; m_n = 3'd0;
            while (chg >= 25) begin chg -= 25; m_q++; end
            while (chg >= 10) begin chg -= 10; m_d++; end
            while (chg >= 5)  begin chg -= 5;  m_n++; end
            m_p   = 3'(chg);
            m_bal = 0;
        end else begin
            m_bal = eff + ins;
        end
        exp_q.push_back(pack(9'(m_bal), ok, fl, rj, (can != 0), m_q, m_d, m_n, m_p));

        @(negedge clk);
        nickel     = (nk != 0);
        dime       = (dm != 0);
        quarter    = (qt != 0);
        dollar     = (dl != 0);
        deduct     = (ded != 0);
        deduct_amt = 9'(amt);
        cancel     = (can != 0);
        @(posedge clk);
        #1;
        obs_w = dut_word();
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            exp_w = exp_q.pop_front();
            check(tag, {5'd0, obs_w}, {5'd0, exp_w});
        end
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; dollar = 1'b0;
        deduct = 1'b0; deduct_amt = 9'd0; cancel = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; dollar = 1'b0;
        deduct = 1'b0; deduct_amt = 9'd0; cancel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_word", {5'd0, dut_word()}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Separate coins
        step(0, 0, 1, 0, 0, 0, 0, "ins_quarter");
        check("plan_bal_25", {23'd0, balance}, 32'd25);
        step(0, 1, 0, 0, 0, 0, 0, "ins_dime");
        check("plan_bal_35", {23'd0, balance}, 32'd35);
        step(1, 0, 0, 0, 0, 0, 0, "ins_nickel");
        check("plan_bal_40", {23'd0, balance}, 32'd40);
        check("plan_no_reject", {31'd0, coin_reject}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, "cancel_40");

        // All coins in one cycle, then purchases
        step(1, 1, 1, 1, 0, 0, 0, "ins_all_four");
        check("plan_bal_140", {23'd0, balance}, 32'd140);
        step(0, 0, 0, 0, 1, 125, 0, "deduct_125");
        check("plan_deduct_ok", {31'd0, deduct_ok}, 32'd1);
        check("plan_bal_15", {23'd0, balance}, 32'd15);
        step(0, 0, 0, 0, 1, 20, 0, "deduct_20_fail");
        check("plan_deduct_fail", {31'd0, deduct_fail}, 32'd1);
        step(1, 0, 0, 0, 1, 20, 0, "deduct_not_funded_by_coin");
        step(0, 0, 0, 0, 1, 20, 0, "deduct_exact");
        step(0, 0, 0, 0, 1, 0, 0, "deduct_zero");

        // 94 cents returned as 3/1/1/4
        step(0, 0, 0, 1, 0, 0, 0, "ins_dollar");
        step(0, 0, 0, 0, 1, 6, 0, "deduct_6");
        step(0, 0, 0, 0, 0, 0, 1, "cancel_94");
        check("plan_q3", {27'd0, quarter_o}, 32'd3);
        check("plan_d1", {29'd0, dime_o}, 32'd1);
        check("plan_n1", {29'd0, nickel_o}, 32'd1);
        check("plan_p4", {29'd0, penny_o}, 32'd4);
        check("plan_cv", {31'd0, change_valid}, 32'd1);

        // Ceiling behaviour
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, "fill_dollar");
        step(0, 0, 1, 0, 0, 0, 0, "fill_quarter");
        step(0, 0, 1, 0, 0, 0, 0, "fill_quarter");
        step(0, 0, 0, 1, 0, 0, 0, "reject_dollar_450");
        check("plan_reject", {31'd0, coin_reject}, 32'd1);
        check("plan_bal_450", {23'd0, balance}, 32'd450);
        step(1, 0, 0, 0, 0, 0, 0, "nickel_455");
        step(1, 0, 0, 0, 0, 0, 0, "nickel_460");
        check("plan_bal_460", {23'd0, balance}, 32'd460);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, "dime_to_500");
        step(1, 0, 0, 0, 0, 0, 0, "reject_at_500");
        step(0, 0, 0, 1, 1, 100, 0, "deduct_makes_room");
        step(1, 0, 0, 0, 1, 511, 0, "deduct_fail_and_reject");
        step(0, 0, 0, 0, 0, 0, 1, "cancel_500");
        step(0, 0, 0, 0, 0, 0, 1, "cancel_zero");

        // Cancel together with coin and deduct
        step(0, 0, 1, 0, 0, 0, 0, "ins_q");
        step(0, 1, 0, 0, 0, 0, 0, "ins_d");
        step(0, 0, 1, 0, 1, 10, 1, "cancel_coin_deduct");
        check("plan_q2", {27'd0, quarter_o}, 32'd2);
        check("plan_d1_b", {29'd0, dime_o}, 32'd1);
        check("plan_no_deduct_pulse", {30'd0, deduct_ok, deduct_fail}, 32'd0);
        check("plan_bal_0", {23'd0, balance}, 32'd0);

        // Random stretch
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 $urandom_range(0, 200), ($urandom_range(0, 9) == 0) ? 1 : 0, "random");
        end

        // Asynchronous reset mid-stream
        step(0, 0, 1, 0, 0, 0, 0, "pre_rst_q");
        step(0, 0, 0, 0, 0, 0, 1, "pre_rst_cancel");
        step(0, 0, 0, 1, 0, 0, 0, "pre_rst_dollar");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_word", {5'd0, dut_word()}, 32'd0);
        m_bal = 0; m_q = 5'd0; m_d = 3'd0; m_n = 3'd0; m_p = 3'd0;
        @(posedge clk);
        #1;
        check("reset_held_word", {5'd0, dut_word()}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, "post_rst_nickel");
        check("plan_bal_5", {23'd0, balance}, 32'd5);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_change_unit.md
Name: coin_change_unit

Overview:
Cash front end of the vending controller. It accumulates inserted coins and bills into a cents balance register and deducts a purchase price on request. On cancel it returns the whole balance as a greedy quarter/dime/nickel/penny breakdown. Sits between the coin-acceptor pulses and the vending FSM, which issues deduct and cancel.

Parameters:
BAL_MAX, 500, maximum balance in cents; must be ≤ 511 to fit the 9-bit balance.

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
nickel  in  1  one-cycle pulse: 5 cents inserted
dime  in  1  one-cycle pulse: 10 cents inserted
quarter  in  1  one-cycle pulse: 25 cents inserted
dollar  in  1  one-cycle pulse: 100 cents inserted
deduct  in  1  one-cycle purchase request
deduct_amt  in  9  price in cents, sampled with deduct
cancel  in  1  one-cycle request to return the full balance
balance  out  9  registered current balance in cents
deduct_ok  out  1  one-cycle pulse: deduction performed
deduct_fail  out  1  one-cycle pulse: insufficient funds, no deduction
coin_reject  out  1  one-cycle pulse: this cycle's coins refused (would exceed BAL_MAX)
change_valid  out  1  one-cycle pulse: new change breakdown on the coin outputs
quarter_o  out  5  quarters to return (0..20)
dime_o  out  3  dimes to return (0..2)
nickel_o  out  3  nickels to return (0..1)
penny_o  out  3  pennies to return (0..4)

Behaviour:
- Reset (rst=0, async): balance=0. quarter_o/dime_o/nickel_o/penny_o=0. All pulse outputs=0.
- All outputs are registered. Responses appear the cycle after the inputs are sampled.
- Coin sum per cycle: ins = 5*nickel + 10*dime + 25*quarter + 100*dollar. Several coins in the same cycle all count.
- Overflow check: if balance_eff + ins > BAL_MAX, ins is treated as 0 and coin_reject pulses. balance_eff is the balance after any deduction that cycle. Coins are never partially accepted.
- Priority when inputs coincide: cancel > deduct.
- Cancel cycle:
  - change = balance + accepted ins.
  - Next cycle: coin outputs load the greedy breakdown of change.
    - q = change/25, r = change%25
    - d = r/10
    - n = (r%10)/5
    - p = r%5
  - change_valid pulses; balance becomes 0.
  - A deduct in the same cycle is ignored: no deduct_ok or deduct_fail.
- Deduct cycle (no cancel):
  - If deduct_amt ≤ registered balance: balance ← balance − deduct_amt + accepted ins; deduct_ok pulses.
  - Otherwise: balance ← balance + accepted ins; deduct_fail pulses. Coins inserted in the same cycle do not fund that deduction.
  - deduct_amt = 0 always succeeds.
- Idle cycle: balance ← balance + accepted ins.
- Coin outputs hold their last breakdown until the next cancel or reset. A cancel with balance 0 loads all zeros and still pulses change_valid.
- Balance never exceeds BAL_MAX and never goes negative. Arithmetic is internally ≥ 10 bits so comparisons never wrap.
- Reset asserted mid-operation discards the balance; no change is emitted.

Test Plan:
- Reset, then quarter, dime, nickel in separate cycles -> balance 25, 35, 40. No reject.
- Same cycle: dollar+quarter+dime+nickel from 0 -> balance 140 next cycle.
- Balance 140, deduct 125 -> deduct_ok, balance 15. Then deduct 20 -> deduct_fail, balance stays 15.
- Balance 94, cancel -> change_valid; quarter_o 3, dime_o 1, nickel_o 1, penny_o 4; balance 0.
- Balance 450, dollar -> coin_reject, balance 450. Then nickel ×2 -> 460.
- Balance 35, cancel together with quarter and deduct 10 -> change 60 (q2, d1, n0, p0); no deduct pulse; balance 0. Async reset mid-stream -> all outputs 0 immediately.
